seg7_scan_decoder: RTL and testbench



---
 rtl/seg7_pkg.sv | 50 +++++
 rtl/seg7_pattern_decode.sv | 35 +++
 rtl/seg7_scan_decoder.sv | 150 +++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants, FSM state type, report payload and helpers for the 7-segment scan decoder.
package seg7_pkg;

    // Active-low segment patterns (bits 6..0 = g..a) for digits 0-9 and the all-off pattern
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] DIGIT_BLANK = 4'hF;
    localparam logic [3:0] DIGIT_ERR   = 4'hE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        PEND  = 2'd2,
        HOLD  = 2'd3
    } seg7_state_t;

    // Report payload held in the output register (position is width-parameterised, kept apart)
    typedef struct packed {
        logic [3:0] digit;
        logic       dp;
        logic       blank;
        logic       err;
    } seg7_rpt_t;

    // True when exactly one bit is set
    function automatic logic is_onehot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

    // Index of the set bit of a one-hot vector
    function automatic logic [4:0] onehot_to_idx(input logic [31:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) idx = 5'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational decode of an active-low 7-segment pattern into a digit value with blank/illegal flags.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_digit_c,
    output logic       o_blank_c,
    output logic       o_err_c
);

    // Pattern lookup; anything outside the legal set is flagged as an error
    always_comb begin
        o_digit_c = DIGIT_ERR;
        o_blank_c = 1'b0;
        o_err_c   = 1'b0;
        case (i_seg)
            SEG_0:     o_digit_c = 4'd0;
            SEG_1:     o_digit_c = 4'd1;
            SEG_2:     o_digit_c = 4'd2;
            SEG_3:     o_digit_c = 4'd3;
            SEG_4:     o_digit_c = 4'd4;
            SEG_5:     o_digit_c = 4'd5;
            SEG_6:     o_digit_c = 4'd6;
            SEG_7:     o_digit_c = 4'd7;
            SEG_8:     o_digit_c = 4'd8;
            SEG_9:     o_digit_c = 4'd9;
            SEG_BLANK: begin
                o_digit_c = DIGIT_BLANK;
                o_blank_c = 1'b1;
            end
            default:   o_err_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Monitors a multiplexed 7-segment bus, debounces each digit and streams per-position changes.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter  int unsigned NUM_DIGITS    = 4,
    parameter  int unsigned STABLE_CYCLES = 4,
    localparam int unsigned POS_W         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            seg_in,
    input  logic [NUM_DIGITS-1:0] dig_sel,
    input  logic                  out_ready,
    input  logic                  clr_ovr,
    output logic                  out_valid,
    output logic [3:0]            out_digit,
    output logic [POS_W-1:0]      out_pos,
    output logic                  out_dp,
    output logic                  out_blank,
    output logic                  out_err,
    output logic                  out_ovr
);

    localparam int unsigned SAMP_W = NUM_DIGITS + 8;
    localparam int unsigned CNT_W  = $clog2(STABLE_CYCLES + 1);

    seg7_state_t                  r_state, w_state_nxt, w_reent_state;
    logic [SAMP_W-1:0]            w_cur, r_sample;
    logic [CNT_W-1:0]             r_cnt, w_cnt_nxt, w_cnt_inc, w_reent_cnt;
    logic                         w_changed, w_cur_onehot, w_match, w_free, w_xfer;
    logic                         w_load, w_set_ovr;
    logic [POS_W-1:0]             w_pos;
    logic [3:0]                   w_digit;
    logic                         w_blank, w_err, w_dp;
    logic [NUM_DIGITS-1:0]        r_known;
    logic [NUM_DIGITS-1:0][4:0]   r_shadow;
    seg7_rpt_t                    r_rpt;
    logic                         r_valid, r_ovr;
    logic [POS_W-1:0]             r_pos;

    assign w_cur         = {dig_sel, seg_in};
    assign w_changed     = (w_cur != r_sample);
    assign w_cur_onehot  = is_onehot(32'(dig_sel));
    assign w_pos         = POS_W'(onehot_to_idx(32'(r_sample[SAMP_W-1:8])));
    assign w_dp          = ~r_sample[7];
    assign w_match       = r_known[w_pos] && (r_shadow[w_pos] == {w_digit, w_dp});
    assign w_cnt_inc     = (r_cnt == CNT_W'(STABLE_CYCLES)) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_reent_state = w_cur_onehot ? TRACK : IDLE;
    assign w_reent_cnt   = w_cur_onehot ? CNT_W'(1) : '0;
    assign w_xfer        = r_valid && out_ready;
    assign w_free        = !r_valid || w_xfer;

    // Decode of the sampled (previous-cycle) pattern
    seg7_pattern_decode u_decode (
        .i_seg     (r_sample[6:0]),
        .o_digit_c (w_digit),
        .o_blank_c (w_blank),
        .o_err_c   (w_err)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state, run counter and load/overrun strobes
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        w_set_ovr   = 1'b0;
        case (r_state)
            IDLE: begin
                w_state_nxt = w_reent_state;
                w_cnt_nxt   = w_reent_cnt;
            end
            TRACK: begin
                if (w_changed) begin
                    w_state_nxt = w_reent_state;
                    w_cnt_nxt   = w_reent_cnt;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == CNT_W'(STABLE_CYCLES))
                        w_state_nxt = w_match ? HOLD : PEND;
                end
            end
            PEND: begin
                // A free register takes the stable pattern even if the input moves on this cycle
                if (w_free)         w_load    = 1'b1;
                else if (w_changed) w_set_ovr = 1'b1;
                if (w_changed) begin
                    w_state_nxt = w_reent_state;
                    w_cnt_nxt   = w_reent_cnt;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_free) w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (w_changed) begin
                    w_state_nxt = w_reent_state;
                    w_cnt_nxt   = w_reent_cnt;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
        endcase
    end

    // Sample history, run counter, per-position shadows and output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sample <= '0;
            r_cnt    <= '0;
            r_known  <= '0;
            r_shadow <= '0;
            r_rpt    <= '0;
            r_pos    <= '0;
            r_valid  <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            r_sample <= w_cur;
            r_cnt    <= w_cnt_nxt;
            if (w_load) begin
                r_rpt.digit       <= w_digit;
                r_rpt.dp          <= w_dp;
                r_rpt.blank       <= w_blank;
                r_rpt.err         <= w_err;
                r_pos             <= w_pos;
                r_valid           <= 1'b1;
                r_known[w_pos]    <= 1'b1;
                r_shadow[w_pos]   <= {w_digit, w_dp};
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end
            if (w_set_ovr)    r_ovr <= 1'b1;
            else if (clr_ovr) r_ovr <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign out_digit = r_rpt.digit;
    assign out_pos   = r_pos;
    assign out_dp    = r_rpt.dp;
    assign out_blank = r_rpt.blank;
    assign out_err   = r_rpt.err;
    assign out_ovr   = r_ovr;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder with a report scoreboard and a standalone decoder sweep.
module tb_seg7_scan_decoder;

    localparam int unsigned NUM_DIGITS    = 4;
    localparam int unsigned STABLE_CYCLES = 4;
    localparam int unsigned POS_W         = 2;

    typedef struct packed {
        logic [POS_W-1:0] pos;
        logic [3:0]       digit;
        logic             dp;
        logic             blank;
        logic             err;
    } exp_t;

    logic                  clk;
    logic                  rst_n;
    logic [7:0]            seg_in;
    logic [NUM_DIGITS-1:0] dig_sel;
    logic                  out_ready;
    logic                  clr_ovr;
    logic                  out_valid;
    logic [3:0]            out_digit;
    logic [POS_W-1:0]      out_pos;
    logic                  out_dp;
    logic                  out_blank;
    logic                  out_err;
    logic                  out_ovr;

    logic [6:0] d_seg;
    logic [3:0] d_digit;
    logic       d_blank;
    logic       d_err;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    logic [6:0] pat_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    seg7_scan_decoder #(
        .NUM_DIGITS    (NUM_DIGITS),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_in    (seg_in),
        .dig_sel   (dig_sel),
        .out_ready (out_ready),
        .clr_ovr   (clr_ovr),
        .out_valid (out_valid),
        .out_digit (out_digit),
        .out_pos   (out_pos),
        .out_dp    (out_dp),
        .out_blank (out_blank),
        .out_err   (out_err),
        .out_ovr   (out_ovr)
    );

    seg7_pattern_decode u_dec (
        .i_seg     (d_seg),
        .o_digit_c (d_digit),
        .o_blank_c (d_blank),
        .o_err_c   (d_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference decode of a full 8-bit bus value at a given position
    function automatic exp_t model(input int pos, input logic [7:0] seg);
        exp_t m;
        m.pos   = POS_W'(pos);
        m.dp    = ~seg[7];
        m.digit = 4'hE;
        m.blank = 1'b0;
        m.err   = 1'b1;
        if (seg[6:0] == 7'h7F) begin
            m.digit = 4'hF;
            m.blank = 1'b1;
            m.err   = 1'b0;
        end else begin
            for (int d = 0; d < 10; d++) begin
                if (seg[6:0] == pat_tab[d]) begin
                    m.digit = 4'(d);
                    m.err   = 1'b0;
                end
            end
        end
        return m;
    endfunction

    function automatic logic [7:0] seg_of(input int d);
        return {1'b1, pat_tab[d]};
    endfunction

    // Scoreboard: every transfer must match the oldest expected report
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            exp_t got;
            exp_t exp;
            got = '{pos: out_pos, digit: out_digit, dp: out_dp, blank: out_blank, err: out_err};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_report got=%h (pos=%0d digit=%h)", got, out_pos, out_digit);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    failures++;
                    $display("FAIL report got=%h exp=%h (pos/digit/dp/blank/err)", got, exp);
                end
            end
        end
    end

    task automatic hold(input logic [NUM_DIGITS-1:0] d, input logic [7:0] s, input int n);
        dig_sel = d;
        seg_in  = s;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        out_ready = 1'b0;
        clr_ovr   = 1'b0;
        dig_sel   = '0;
        seg_in    = 8'hFF;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_decoder();
        for (int i = 0; i < 128; i++) begin
            exp_t m;
            d_seg = 7'(i);
            #1;
            m = model(0, {1'b1, 7'(i)});
            checks++;
            if ({d_digit, d_blank, d_err} !== {m.digit, m.blank, m.err}) begin
                failures++;
                $display("FAIL decode_%02h got=%h/%b/%b exp=%h/%b/%b", i, d_digit, d_blank, d_err,
                         m.digit, m.blank, m.err);
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({out_valid, out_digit, out_pos, out_dp, out_blank, out_err, out_ovr} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got v=%b d=%h p=%0d dp=%b b=%b e=%b o=%b exp all zero",
                     out_valid, out_digit, out_pos, out_dp, out_blank, out_err, out_ovr);
        end
        hold(4'b0000, 8'hC0, 8);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL no_onehot_no_report got=%b exp=0", out_valid);
        end
        hold(4'b0110, 8'h7E, 8);
        checks++;
        if ({out_valid, out_err} !== 2'b00) begin
            failures++;
            $display("FAIL multihot_ignored got=%b exp=00", {out_valid, out_err});
        end
    endtask

    task automatic test_latency();
        apply_reset();
        out_ready = 1'b1;
        exp_q.push_back(model(0, 8'hC0));
        hold(4'b0001, 8'hC0, STABLE_CYCLES);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL latency_early got=%b exp=0", out_valid);
        end
        hold(4'b0001, 8'hC0, 1);
        checks++;
        if ({out_valid, out_pos, out_digit, out_dp} !== {1'b1, 2'd0, 4'd0, 1'b0}) begin
            failures++;
            $display("FAIL latency_edge got v=%b p=%0d d=%h dp=%b exp v=1 p=0 d=0 dp=0",
                     out_valid, out_pos, out_digit, out_dp);
        end
        hold(4'b0001, 8'hC0, 5);
        checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL latency_single got pending=%0d v=%b exp 0 0", exp_q.size(), out_valid);
        end
    endtask

    task automatic test_scan();
        apply_reset();
        out_ready = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            for (int p = 0; p < 4; p++) begin
                if (pass == 0) exp_q.push_back(model(p, seg_of(p + 1)));
                hold(NUM_DIGITS'(1 << p), seg_of(p + 1), 6);
            end
        end
        exp_q.push_back(model(2, 8'h92));
        hold(4'b0100, 8'h92, 8);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scan_reports got pending=%0d exp=0", exp_q.size());
        end
    endtask

    task automatic test_dp_blank();
        apply_reset();
        out_ready = 1'b1;
        exp_q.push_back(model(0, 8'h40));
        hold(4'b0001, 8'h40, 8);
        exp_q.push_back(model(0, 8'hFF));
        hold(4'b0001, 8'hFF, 8);
        exp_q.push_back(model(0, 8'h7F));
        hold(4'b0001, 8'h7F, 8);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL dp_blank_reports got pending=%0d exp=0", exp_q.size());
        end
    endtask

    task automatic test_glitch_illegal();
        apply_reset();
        out_ready = 1'b1;
        exp_q.push_back(model(0, 8'hB0));
        hold(4'b0001, 8'hB0, STABLE_CYCLES - 1);
        hold(4'b0001, 8'h82, 1);
        hold(4'b0001, 8'hB0, STABLE_CYCLES);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL glitch_early got=%b exp=0", out_valid);
        end
        hold(4'b0001, 8'hB0, 1);
        checks++;
        if ({out_valid, out_digit} !== {1'b1, 4'd3}) begin
            failures++;
            $display("FAIL glitch_report got v=%b d=%h exp v=1 d=3", out_valid, out_digit);
        end
        hold(4'b0001, 8'hB0, 3);
        exp_q.push_back(model(1, 8'h7E));
        hold(4'b0010, 8'h7E, 8);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL illegal_reports got pending=%0d exp=0", exp_q.size());
        end
    endtask

    task automatic test_overrun();
        apply_reset();
        exp_q.push_back(model(0, 8'hF8));
        hold(4'b0001, 8'hF8, 6);
        hold(4'b0010, 8'h80, 6);
        clr_ovr = 1'b1;
        hold(4'b0000, 8'hFF, 1);
        clr_ovr = 1'b0;
        checks++;
        if ({out_ovr, out_valid, out_pos, out_digit} !== {1'b1, 1'b1, 2'd0, 4'd7}) begin
            failures++;
            $display("FAIL ovr_set got o=%b v=%b p=%0d d=%h exp o=1 v=1 p=0 d=7",
                     out_ovr, out_valid, out_pos, out_digit);
        end
        hold(4'b0000, 8'hFF, 3);
        checks++;
        if (out_ovr !== 1'b1) begin
            failures++;
            $display("FAIL ovr_sticky got=%b exp=1", out_ovr);
        end
        clr_ovr = 1'b1;
        hold(4'b0000, 8'hFF, 1);
        clr_ovr = 1'b0;
        checks++;
        if (out_ovr !== 1'b0) begin
            failures++;
            $display("FAIL ovr_clear got=%b exp=0", out_ovr);
        end
        out_ready = 1'b1;
        hold(4'b0000, 8'hFF, 3);
        checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL ovr_drain got pending=%0d v=%b exp 0 0", exp_q.size(), out_valid);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        exp_q.push_back(model(0, 8'hF9));
        hold(4'b0001, 8'hF9, 6);
        exp_q.push_back(model(1, 8'hA4));
        hold(4'b0010, 8'hA4, 6);
        out_ready = 1'b1;
        hold(4'b0010, 8'hA4, 1);
        checks++;
        if ({out_valid, out_pos, out_digit, out_ovr} !== {1'b1, 2'd1, 4'd2, 1'b0}) begin
            failures++;
            $display("FAIL b2b_replace got v=%b p=%0d d=%h o=%b exp v=1 p=1 d=2 o=0",
                     out_valid, out_pos, out_digit, out_ovr);
        end
        hold(4'b0010, 8'hA4, 3);
        checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drain got pending=%0d v=%b exp 0 0", exp_q.size(), out_valid);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        hold(4'b1000, 8'h90, 6);
        hold(4'b0100, 8'hC0, 6);
        checks++;
        if ({out_valid, out_pos, out_digit} !== {1'b1, 2'd3, 4'd9}) begin
            failures++;
            $display("FAIL arst_setup got v=%b p=%0d d=%h exp v=1 p=3 d=9", out_valid, out_pos, out_digit);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_digit, out_pos, out_dp, out_blank, out_err, out_ovr} !== '0) begin
            failures++;
            $display("FAIL arst_outputs got v=%b d=%h p=%0d dp=%b b=%b e=%b o=%b exp all zero",
                     out_valid, out_digit, out_pos, out_dp, out_blank, out_err, out_ovr);
        end
        @(posedge clk);
        #2;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        exp_q.push_back(model(2, 8'hC0));
        hold(4'b0100, 8'hC0, 8);
        checks++;
        if (exp_q.size() != 0 || out_ovr !== 1'b0) begin
            failures++;
            $display("FAIL arst_rereport got pending=%0d o=%b exp 0 0", exp_q.size(), out_ovr);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b0;
        clr_ovr   = 1'b0;
        dig_sel   = '0;
        seg_in    = 8'hFF;
        d_seg     = '0;
        test_decoder();
        test_reset();
        test_latency();
        test_scan();
        test_dp_blank();
        test_glitch_illegal();
        test_overrun();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
